mdu_sequencer: RTL

- Controls the iterative multiply/divide unit in the EX stage of the pipelined MIPS core.
- Accepts a start pulse from decode/EX and loads the operands.
- Issues per-cycle step enables to the shift/add datapath, using its own cycle counter with load, pause and wrap.
- Writes HI/LO on completion, and stalls the pipeline on a structural or data hazard against an in-flight operation.

---
 rtl/mdu_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// +--------------------------------------------------------------------+
// | mdu_sequencer                                                      |
// | Sequencer for the iterative multiply/divide unit in the EX stage.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module mdu_sequencer #(
   parameter int MUL_CYCLES = 32,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_WIDTH  = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic                 div_zero,
   input  logic                 hold,
   input  logic                 flush,
   input  logic                 mf_req,
   output logic                 ld_operands,
   output logic                 step_en,
   output logic [1:0]           op_q,
   output logic                 wr_hilo,
   output logic                 dz_flag,
   output logic                 busy,
   output logic                 stall,
   output logic [CNT_WIDTH-1:0] step_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_mul_last = CNT_WIDTH'(MUL_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_div_last = CNT_WIDTH'(DIV_CYCLES - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [CNT_WIDTH-1:0]  w_cnt_next;
   logic [CNT_WIDTH-1:0]  w_last;
   logic [1:0]            r_op;
   logic                  r_dz;
   logic                  w_accept;

   // Iteration count depends only on the latched op, never the live input.
   assign w_last = r_op[1] ? c_div_last : c_mul_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= 2'b00;
         r_dz    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_op <= op;
            r_dz <= div_zero;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !flush) begin
               w_accept     = 1'b1;
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_cnt_next = '0;
            if (flush)
               w_state_next = S_IDLE;
            else if (r_dz && r_op[1])
               w_state_next = S_DONE;
            else
               w_state_next = S_RUN;
         end
         S_RUN: begin
            // Flush takes priority over a concurrent hold.
            if (flush) begin
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end else if (!hold) begin
               if (r_cnt == w_last) begin
                  w_cnt_next   = '0;
                  w_state_next = S_DONE;
               end else begin
                  w_cnt_next = r_cnt + CNT_WIDTH'(1);
               end
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign ld_operands = (r_state == S_LOAD);
   assign step_en     = (r_state == S_RUN) && !hold;
   assign wr_hilo     = (r_state == S_DONE);
   assign dz_flag     = (r_state == S_DONE) && r_dz;
   assign busy        = (r_state != S_IDLE);
   assign stall       = busy && (start || mf_req);
   assign op_q        = r_op;
   assign step_cnt    = r_cnt;

endmodule

`default_nettype wire
